// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - multi-channel key/switch synchroniser and debouncer with press/release pulses
module key_debouncer #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [N-1:0] KEY_IN,
    output logic [N-1:0] PRESSED,
    output logic [N-1:0] PRESS,
    output logic [N-1:0] RELEASE
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_DOWN,
        S_RELEASE_WAIT
    } state_t;

    logic [N-1:0]  sync1_q, sync1_d;
    logic [N-1:0]  sync2_q, sync2_d;
    logic [N-1:0]  pressed_q, pressed_d;
    logic [N-1:0]  press_q, press_d;
    logic [N-1:0]  rel_q, rel_d;
    state_t        state_q [N];
    state_t        state_d [N];
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    // Normalise to 1 = pressed before the synchroniser so reset-to-0 means released.
    always_comb begin
        sync1_d = (ACTIVE_LOW != 0) ? ~KEY_IN : KEY_IN;
        sync2_d = sync1_q;
    end

    always_comb begin
        pressed_d = pressed_q;
        press_d   = '0;
        rel_d     = '0;
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (sync2_q[i]) begin
                        state_d[i] = S_PRESS_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = S_IDLE;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]   = S_DOWN;
                        pressed_d[i] = 1'b1;
                        press_d[i]   = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                S_DOWN: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = S_RELEASE_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                S_RELEASE_WAIT: begin
                    if (sync2_q[i]) begin
                        state_d[i] = S_DOWN;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]   = S_IDLE;
                        pressed_d[i] = 1'b0;
                        rel_d[i]     = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            pressed_q <= '0;
            press_q   <= '0;
            rel_q     <= '0;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            rel_q     <= rel_d;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign PRESSED = pressed_q;
    assign PRESS   = press_q;
    assign RELEASE = rel_q;

endmodule

// File: tb/tb_key_debouncer.sv
// tb/tb_key_debouncer.sv - directed-vector bench for key_debouncer
module tb_key_debouncer;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_al;
    logic [3:0] key_ah;
    logic [3:0] pressed_al, press_al, release_al;
    logic [3:0] pressed_ah, press_ah, release_ah;

    int n_checks;
    int n_errors;

    key_debouncer #(.N(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1)) dut_al (
        .CLK     (clk),
        .RST_N   (rst_n),
        .KEY_IN  (key_al),
        .PRESSED (pressed_al),
        .PRESS   (press_al),
        .RELEASE (release_al)
    );

    key_debouncer #(.N(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0)) dut_ah (
        .CLK     (clk),
        .RST_N   (rst_n),
        .KEY_IN  (key_ah),
        .PRESSED (pressed_ah),
        .PRESS   (press_ah),
        .RELEASE (release_ah)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n  = 1'b0;
        key_al = 4'b1111;
        key_ah = 4'b0000;
        tick(3);
        check("reset_pressed", {28'd0, pressed_al}, 32'h0);
        check("reset_press",   {28'd0, press_al},   32'h0);
        check("reset_release", {28'd0, release_al}, 32'h0);
        rst_n = 1'b1;

        // all keys released (all-1, active low) straight out of reset: no events
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("idle_nopulse", {24'd0, press_al, release_al}, 32'h0);
        end
        check("idle_pressed", {28'd0, pressed_al}, 32'h0);

        // clean press on channel 0
        key_al = 4'b1110;
        tick(6);
        check("clean_early", {28'd0, press_al}, 32'h0);
        tick(1);
        check("clean_press",   {28'd0, press_al},   32'h1);
        check("clean_pressed", {28'd0, pressed_al}, 32'h1);
        tick(1);
        check("clean_pulse_end", {28'd0, press_al},   32'h0);
        check("clean_held",      {28'd0, pressed_al}, 32'h1);

        // bounce on channel 1: low 2, high 1, then low held
        key_al = 4'b1100;
        tick(1);
        check("bounce_a", {28'd0, press_al}, 32'h0);
        tick(1);
        check("bounce_b", {28'd0, press_al}, 32'h0);
        key_al = 4'b1110;
        tick(1);
        check("bounce_c", {28'd0, press_al}, 32'h0);
        key_al = 4'b1100;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("bounce_wait", {24'd0, press_al, pressed_al}, 32'h01);
        end
        tick(1);
        check("bounce_press",   {28'd0, press_al},   32'h2);
        check("bounce_pressed", {28'd0, pressed_al}, 32'h3);
        tick(1);
        check("bounce_once", {28'd0, press_al}, 32'h0);

        // release channel 0
        key_al = 4'b1101;
        tick(6);
        check("rel_early", {24'd0, release_al, pressed_al}, 32'h03);
        tick(1);
        check("rel_pulse",   {28'd0, release_al}, 32'h1);
        check("rel_pressed", {28'd0, pressed_al}, 32'h2);
        tick(1);
        check("rel_pulse_end", {28'd0, release_al}, 32'h0);

        // one-cycle release glitch on channel 1
        key_al = 4'b1111;
        tick(1);
        key_al = 4'b1101;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("glitch_hold", {20'd0, press_al, release_al, pressed_al}, 32'h002);
        end

        key_al = 4'b1111;
        tick(10);
        check("cleanup", {28'd0, pressed_al}, 32'h0);

        // hold channel 3, then reset while channel 2 sits in PRESS_WAIT with cnt=2
        key_al = 4'b0111;
        tick(7);
        check("ch3_press", {24'd0, press_al, pressed_al}, 32'h88);
        key_al = 4'b0011;
        tick(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {20'd0, pressed_al, press_al, release_al}, 32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(6);
        check("post_rst_early", {24'd0, press_al, pressed_al}, 32'h0);
        tick(1);
        check("post_rst_press",   {28'd0, press_al},   32'hc);
        check("post_rst_pressed", {28'd0, pressed_al}, 32'hc);

        // simultaneous release of channels 2 and 3
        key_al = 4'b1111;
        tick(7);
        check("sim_rel_23", {28'd0, release_al}, 32'hc);
        tick(1);
        check("sim_rel_23_end", {28'd0, release_al}, 32'h0);

        // simultaneous press/release of channels 0 and 3
        key_al = 4'b0110;
        tick(7);
        check("sim_press_03", {28'd0, press_al}, 32'h9);
        tick(1);
        check("sim_press_03_end", {28'd0, press_al}, 32'h0);
        key_al = 4'b1111;
        tick(6);
        check("sim_rel_03_early", {28'd0, release_al}, 32'h0);
        tick(1);
        check("sim_rel_03",     {28'd0, release_al}, 32'h9);
        check("sim_rel_03_lvl", {28'd0, pressed_al}, 32'h0);

        // active-high instance
        check("ah_idle", {24'd0, pressed_ah, press_ah}, 32'h0);
        key_ah = 4'b0001;
        tick(6);
        check("ah_early", {28'd0, press_ah}, 32'h0);
        tick(1);
        check("ah_press",   {28'd0, press_ah},   32'h1);
        check("ah_pressed", {28'd0, pressed_ah}, 32'h1);
        check("ah_no_rel",  {28'd0, release_ah}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Multi-channel push-button/switch conditioner that sits directly upstream of the decimal counter/display stage on the board. It synchronises raw `KEY`/`SW` levels into the `CLK` domain and rejects contact bounce with a per-channel stability counter. It delivers a clean debounced level plus single-cycle press and release pulses, so the counter advances exactly once per physical press.

## Interface
- `N`, 4: number of independent channels.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a change; legal range ≥1 (10 ms at 50 MHz).
- `ACTIVE_LOW`, 1: 1 means raw input 0 = pressed (DE2 `KEY`); 0 means raw input 1 = pressed (`SW`).
- `CLK  input  1  system clock, all state on rising edge`
- `RST_N  input  1  asynchronous, active-low reset`
- `KEY_IN  input  N  raw asynchronous button/switch levels`
- `PRESSED  output  N  debounced level, 1 = pressed, registered`
- `PRESS  output  N  one-cycle pulse on accepted press, registered`
- `RELEASE  output  N  one-cycle pulse on accepted release, registered`

## Operation
- Per channel: normalise `p = KEY_IN[i] ^ ACTIVE_LOW`, giving 1 = pressed. Pass `p` through a 2-flop synchroniser to get `s`.
- Per-channel FSM with counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`. The FSM has 4 states:
  - **IDLE** (`PRESSED`=0): if `s`=1, go to PRESS_WAIT with `cnt`←0.
  - **PRESS_WAIT**:
    - if `s`=0, return to IDLE; any bounce restarts qualification.
    - else if `cnt`==`DEBOUNCE_CYCLES`-1, go to DOWN, set `PRESSED`←1 and `PRESS`←1.
    - else `cnt`←`cnt`+1.
  - **DOWN** (`PRESSED`=1): if `s`=0, go to RELEASE_WAIT with `cnt`←0.
  - **RELEASE_WAIT**:
    - if `s`=1, return to DOWN.
    - else if `cnt`==`DEBOUNCE_CYCLES`-1, go to IDLE, set `PRESSED`←0 and `RELEASE`←1.
    - else `cnt`←`cnt`+1.
- `PRESS`/`RELEASE` are high only in the cycle after the accepting transition and are 0 otherwise.
- `PRESS` and `RELEASE` for the same channel are never high in the same cycle.
- Channels are fully independent; simultaneous events on different channels each produce their own pulses in the same cycle.
- `cnt` never exceeds `DEBOUNCE_CYCLES`-1; no wrap-around is possible.
- Reset, asserted asynchronously at any time including mid-wait:
  - all FSMs go to IDLE and `cnt`=0;
  - synchroniser flops are set to 0 (released);
  - `PRESSED`, `PRESS`, `RELEASE` all 0.
  - A button held through reset is accepted as a new press after release of `RST_N` plus the normal latency.
- `RST_N` deassertion is assumed synchronous to `CLK` at the board level; no internal reset synchroniser.

## Timing
- Press latency: `KEY_IN` changes before edge 0 → `s` valid after edge 1 → PRESS_WAIT after edge 2 → `PRESSED` and `PRESS` high after edge `DEBOUNCE_CYCLES`+2.
- Release latency is symmetric, also `DEBOUNCE_CYCLES`+2 cycles.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no output change.
- Pulse width is exactly 1 `CLK` cycle. Minimum spacing between `PRESS` and the following `RELEASE` is `DEBOUNCE_CYCLES`+1 cycles.
- With `DEBOUNCE_CYCLES`=1, latency is 3 cycles.
- All outputs are registered; there is no combinational path from `KEY_IN` to any output.

## Test plan
- Clean press, `N`=4, `DEBOUNCE_CYCLES`=4, `ACTIVE_LOW`=1: drive `KEY_IN[0]` 1→0 before edge 0 → `PRESSED[0]`=1 and `PRESS[0]`=1 after edge 6; `PRESS[0]`=0 after edge 7; other channels stay 0.
- Bounce rejection: `KEY_IN[1]` low for 2 cycles, high for 1, then low and held → no output during the bounce; `PRESS[1]` fires exactly once, 6 cycles after the final low.
- Release: from DOWN, drive `KEY_IN[0]` high → `RELEASE[0]` one-cycle pulse and `PRESSED[0]`=0 after 6 cycles. A 1-cycle release glitch leaves `PRESSED[0]`=1 with no pulses.
- Reset mid-operation: assert `RST_N`=0 while channel 2 is in PRESS_WAIT with `cnt`=2 → all outputs 0 immediately. Release `RST_N` with the key still held → `PRESS[2]` 6 cycles later.
- Simultaneous: press channels 0 and 3 on the same edge → `PRESS`=4'b1001 in a single cycle. Release both → `RELEASE`=4'b1001.
- Polarity: `ACTIVE_LOW`=0, `KEY_IN[0]` 0→1 → `PRESS[0]` after 6 cycles. Holding `KEY_IN` at all-1 through reset with `ACTIVE_LOW`=1 → no pulses.
